// File: rtl/trencadis_pwm_pkg.sv
// Shared types for the trencadis PWM generator.
// Optional dead-time insertion is enabled with TRENCADIS_PWM_DEADTIME_EN.
package trencadis_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_e;

  function automatic logic is_active(input pwm_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/trencadis_deadtime_inserter.sv
// Turns a raw PWM level into a complementary pair with a programmable dead band.
// Present only when TRENCADIS_PWM_DEADTIME_EN is defined.
`ifdef TRENCADIS_PWM_DEADTIME_EN
module trencadis_deadtime_inserter #(
  parameter int DT_SIZE = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               raw_i,
  input  logic [DT_SIZE-1:0] dead_time_i,
  output logic               pwm_o,
  output logic               pwm_n_o
);

  logic               raw_q;
  logic [DT_SIZE-1:0] band_q, band_d;
  logic               pwm_q, pwm_d;
  logic               pwm_n_q, pwm_n_d;

  // raw_i is the level of the upcoming cycle; any toggle (re)starts the band.
  always_comb begin
    band_d = band_q;
    if (raw_i != raw_q) begin
      band_d = dead_time_i;
    end else if (band_q != '0) begin
      band_d = band_q - 1'b1;
    end
    pwm_d   = run_i && (band_d == '0) && raw_i;
    pwm_n_d = run_i && (band_d == '0) && !raw_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q   <= 1'b0;
      band_q  <= '0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      raw_q   <= raw_i;
      band_q  <= band_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign pwm_n_o = pwm_n_q;

endmodule
`endif

// File: rtl/trencadis_pwm_generator.sv
// Tick-driven PWM generator with shadow-buffered period/duty and graceful stop.
// Define TRENCADIS_PWM_DEADTIME_EN to add dead_time_i and dead-band insertion.
module trencadis_pwm_generator
  import trencadis_pwm_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int DT_SIZE = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               tick_i,
  input  logic [SIZE-1:0]    period_i,
  input  logic [SIZE-1:0]    duty_i,
  input  logic               update_i,
`ifdef TRENCADIS_PWM_DEADTIME_EN
  input  logic [DT_SIZE-1:0] dead_time_i,
`endif
  output logic               pwm_o,
  output logic               pwm_n_o,
  output logic               period_end_o,
  output logic               update_pending_o,
  output logic               running_o
);

  pwm_state_e      state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] period_q, period_d;
  logic [SIZE-1:0] duty_q, duty_d;
  logic [SIZE-1:0] pend_period_q, pend_period_d;
  logic [SIZE-1:0] pend_duty_q, pend_duty_d;
  logic            pending_q, pending_d;
  logic            period_end_q, period_end_d;
  logic            running_q, running_d;
  logic            raw_d;
  logic            wrap;

  assign wrap = is_active(state_q) && tick_i && (cnt_q == period_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A re-request during DRAIN wins over the wrap that would end it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = RUN;
      RUN:     if (!en_i) state_d = DRAIN;
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    period_d      = period_q;
    duty_d        = duty_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pending_d     = pending_q;
    if (!is_active(state_q)) begin
      cnt_d = '0;
      if (update_i) begin
        period_d = period_i;
        duty_d   = duty_i;
      end
    end else begin
      if (tick_i) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      // Apply the old pending pair first so a same-cycle update is deferred.
      if (wrap && pending_q) begin
        period_d  = pend_period_q;
        duty_d    = pend_duty_q;
        pending_d = 1'b0;
      end
      if (update_i) begin
        pend_period_d = period_i;
        pend_duty_d   = duty_i;
        pending_d     = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so the registered outputs
  // line up with the cycle's cnt_q/duty_q/state.
  always_comb begin
    running_d    = is_active(state_d);
    raw_d        = running_d && (cnt_d < duty_d);
    period_end_d = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      period_q      <= '0;
      duty_q        <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pending_q     <= 1'b0;
      period_end_q  <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pending_q     <= pending_d;
      period_end_q  <= period_end_d;
      running_q     <= running_d;
    end
  end

  assign period_end_o     = period_end_q;
  assign update_pending_o = pending_q;
  assign running_o        = running_q;

`ifdef TRENCADIS_PWM_DEADTIME_EN
  logic [DT_SIZE-1:0] dead_time_q, dead_time_d;

  assign dead_time_d = (!is_active(state_q) || wrap) ? dead_time_i : dead_time_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dead_time_q <= '0;
    end else begin
      dead_time_q <= dead_time_d;
    end
  end

  trencadis_deadtime_inserter #(
    .DT_SIZE(DT_SIZE)
  ) u_deadtime (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .run_i      (running_d),
    .raw_i      (raw_d),
    .dead_time_i(dead_time_q),
    .pwm_o      (pwm_o),
    .pwm_n_o    (pwm_n_o)
  );
`else
  logic pwm_q, pwm_n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      pwm_q   <= raw_d;
      pwm_n_q <= running_d && !raw_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign pwm_n_o = pwm_n_q;

  // DT_SIZE only shapes hardware when dead-time insertion is built in.
  if (DT_SIZE < 1) begin : g_dt_size_invalid
  end
`endif

endmodule

// File: tb/tb_trencadis_pwm_generator.sv
// Scoreboard bench for trencadis_pwm_generator; a behavioural model pushes the
// expected output vector each cycle and every task pops and compares inline.
module tb_trencadis_pwm_generator;

  logic       clk_i    = 1'b0;
  logic       rst_ni   = 1'b0;
  logic       en_i     = 1'b0;
  logic       tick_i   = 1'b0;
  logic       update_i = 1'b0;
  logic [7:0] period_i = 8'd0;
  logic [7:0] duty_i   = 8'd0;
  logic       pwm_o, pwm_n_o, period_end_o, update_pending_o, running_o;
`ifdef TRENCADIS_PWM_DEADTIME_EN
  logic [3:0] dead_time_i = 4'd0;
  localparam logic [4:0] CMP_MASK = 5'b00111;
`else
  localparam logic [4:0] CMP_MASK = 5'b11111;
`endif

  logic [4:0] obs;
  assign obs = {pwm_o, pwm_n_o, period_end_o, update_pending_o, running_o};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];

  trencadis_pwm_generator #(.SIZE(8), .DT_SIZE(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .tick_i          (tick_i),
    .period_i        (period_i),
    .duty_i          (duty_i),
    .update_i        (update_i),
`ifdef TRENCADIS_PWM_DEADTIME_EN
    .dead_time_i     (dead_time_i),
`endif
    .pwm_o           (pwm_o),
    .pwm_n_o         (pwm_n_o),
    .period_end_o    (period_end_o),
    .update_pending_o(update_pending_o),
    .running_o       (running_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: 0 = idle, 1 = run, 2 = drain.
  int         m_state;
  logic [7:0] m_cnt, m_per, m_duty, m_pp, m_pd;
  bit         m_pend;

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_per = 0; m_duty = 0; m_pp = 0; m_pd = 0; m_pend = 0;
  endfunction

  function automatic logic [4:0] model_step(input logic en, input logic tick, input logic upd,
                                            input logic [7:0] per, input logic [7:0] duty);
    bit wrap, run, pwm;
    wrap = (m_state != 0) && tick && (m_cnt == m_per);
    if (m_state == 0) begin
      if (upd) begin m_per = per; m_duty = duty; end
      m_cnt = 0;
      if (en) m_state = 1;
    end else begin
      if (tick) m_cnt = wrap ? 8'd0 : m_cnt + 8'd1;
      if (wrap && m_pend) begin m_per = m_pp; m_duty = m_pd; m_pend = 0; end
      if (upd) begin m_pp = per; m_pd = duty; m_pend = 1; end
      if (m_state == 1) begin
        if (!en) m_state = 2;
      end else if (en) m_state = 1;
      else if (wrap) m_state = 0;
    end
    run = (m_state != 0);
    pwm = run && (m_cnt < m_duty);
    return {pwm, run && !pwm, wrap, m_pend, run};
  endfunction

  task automatic drive(input logic en, input logic tick, input logic upd,
                       input logic [7:0] per, input logic [7:0] duty);
    en_i = en; tick_i = tick; update_i = upd; period_i = per; duty_i = duty;
    exp_q.push_back(model_step(en, tick, upd, per, duty));
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    rst_ni = 1'b0;
    #7;
    n_cmp++;
    if (obs !== 5'b00000) begin
      n_fail++; $display("FAIL reset_state: got %b want 00000", obs);
    end
    #10 rst_ni = 1'b1;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL idle_after_reset step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp;
    int highs = 0, pes = 0;
    for (int i = 0; i < 35; i++) begin
      drive(i >= 1 && i <= 24, 1'b1, i == 0, 8'd7, 8'd3);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL basic step %0d: got %b want %b", i, obs, exp);
      end
      if (i >= 1 && i <= 24) begin
        highs += int'(pwm_o);
        pes   += int'(period_end_o);
      end
    end
`ifndef TRENCADIS_PWM_DEADTIME_EN
    n_cmp++;
    if (highs != 9) begin n_fail++; $display("FAIL basic_high_count: got %0d want 9", highs); end
`endif
    n_cmp++;
    if (pes != 2) begin n_fail++; $display("FAIL basic_period_end_count: got %0d want 2", pes); end
    n_cmp++;
    if (running_o !== 1'b0) begin n_fail++; $display("FAIL basic_stopped: got %b want 0", running_o); end
  endtask

  task automatic test_pulse_base();
    logic [4:0] exp;
    int highs = 0, pes = 0;
    for (int i = 0; i < 50; i++) begin
      drive(i >= 1 && i <= 32, i[0], i == 0, 8'd3, 8'd2);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL pulse_base step %0d: got %b want %b", i, obs, exp);
      end
      if (i >= 1 && i <= 32) begin
        highs += int'(pwm_o);
        pes   += int'(period_end_o);
      end
    end
`ifndef TRENCADIS_PWM_DEADTIME_EN
    n_cmp++;
    if (highs != 16) begin n_fail++; $display("FAIL pulse_base_high_count: got %0d want 16", highs); end
`endif
    n_cmp++;
    if (pes != 3) begin n_fail++; $display("FAIL pulse_base_period_end_count: got %0d want 3", pes); end
  endtask

  task automatic test_duty_extremes();
    logic [4:0] exp;
    for (int t = 0; t < 2; t++) begin
      int highs = 0, lows_n = 0;
      for (int i = 0; i < 20; i++) begin
        drive(i >= 1 && i <= 9, 1'b1, i == 0, 8'd7, (t == 1) ? 8'd9 : 8'd0);
        exp = exp_q.pop_front();
        n_cmp++;
        if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
          n_fail++; $display("FAIL duty_extreme%0d step %0d: got %b want %b", t, i, obs, exp);
        end
        highs  += int'(pwm_o);
        lows_n += int'(pwm_n_o);
      end
`ifndef TRENCADIS_PWM_DEADTIME_EN
      n_cmp++;
      if (highs != ((t == 1) ? 16 : 0)) begin
        n_fail++; $display("FAIL duty_extreme%0d_high_count: got %0d want %0d", t, highs, (t == 1) ? 16 : 0);
      end
      if (t == 1) begin
        n_cmp++;
        if (lows_n != 0) begin n_fail++; $display("FAIL duty_full_pwm_n_count: got %0d want 0", lows_n); end
      end
`endif
    end
  endtask

  task automatic test_shadow();
    logic [4:0] exp;
    logic [7:0] d;
    int hi[3] = '{0, 0, 0};
    for (int i = 0; i < 45; i++) begin
      d = (i == 3) ? 8'd6 : (i == 12) ? 8'd5 : (i == 17) ? 8'd1 : 8'd3;
      drive(i >= 1 && i <= 34, 1'b1, i == 0 || i == 3 || i == 12 || i == 17, 8'd7, d);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL shadow step %0d: got %b want %b", i, obs, exp);
      end
      if (i >= 1 && i <= 24) hi[(i - 1) / 8] += int'(pwm_o);
      if (i == 3 || i == 9 || i == 17 || i == 25) begin
        n_cmp++;
        if (update_pending_o !== ((i == 3 || i == 17) ? 1'b1 : 1'b0)) begin
          n_fail++; $display("FAIL shadow_pending at %0d: got %b want %b", i, update_pending_o, (i == 3 || i == 17));
        end
      end
    end
`ifndef TRENCADIS_PWM_DEADTIME_EN
    n_cmp++;
    if (hi[0] != 3 || hi[1] != 6 || hi[2] != 5) begin
      n_fail++; $display("FAIL shadow_high_per_period: got %0d/%0d/%0d want 3/6/5", hi[0], hi[1], hi[2]);
    end
`endif
  endtask

  task automatic test_stop();
    logic [4:0] exp;
    for (int i = 0; i < 37; i++) begin
      drive((i >= 1 && i <= 12 && i != 4 && i != 5) || i >= 31, 1'b1, i == 0, 8'd7, 8'd3);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL stop step %0d: got %b want %b", i, obs, exp);
      end
      if (i >= 4 && i <= 6) begin
        n_cmp++;
        if (running_o !== 1'b1) begin n_fail++; $display("FAIL drain_rearm at %0d: got %b want 1", i, running_o); end
      end
      if (i == 17) begin
        n_cmp++;
        if ({period_end_o, running_o} !== 2'b10) begin
          n_fail++; $display("FAIL final_wrap: got pe/run %b%b want 10", period_end_o, running_o);
        end
      end
    end
    #3 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL async_reset: got %b want 00000", obs); end
    #2 rst_ni = 1'b1;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL post_reset step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

`ifdef TRENCADIS_PWM_DEADTIME_EN
  task automatic test_deadtime();
    logic [4:0] exp;
    logic p[40];
    logic n[40];
    dead_time_i = 4'd2;
    for (int i = 0; i < 40; i++) begin
      drive(i >= 1, 1'b1, i == 0, 8'd7, 8'd3);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL deadtime step %0d: got %b want %b", i, obs, exp);
      end
      p[i] = pwm_o;
      n[i] = pwm_n_o;
    end
    for (int i = 1; i < 38; i++) begin
      n_cmp++;
      if (p[i] && n[i]) begin n_fail++; $display("FAIL dt_overlap at %0d: got 11 want not both", i); end
      if (p[i-1] && !p[i]) begin
        n_cmp++;
        if ({n[i+1], n[i+2]} !== 2'b01) begin
          n_fail++; $display("FAIL dt_gap_fall at %0d: got %b%b want 01", i, n[i+1], n[i+2]);
        end
      end
      if (n[i-1] && !n[i]) begin
        n_cmp++;
        if ({p[i+1], p[i+2]} !== 2'b01) begin
          n_fail++; $display("FAIL dt_gap_rise at %0d: got %b%b want 01", i, p[i+1], p[i+2]);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'd7, 8'd3);
      exp = exp_q.pop_front();
      n_cmp++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL deadtime_drain step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_pulse_base();
    test_duty_extremes();
    test_shadow();
    test_stop();
`ifdef TRENCADIS_PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
